bulk_endp_sched: RTL and testbench

Transaction scheduler between the SIE and N_ENDP bulk endpoint instances. It decodes each token, latches the addressed endpoint for the whole transaction, and routes the SIE IN/OUT handshake to that endpoint only. It muxes data and NAK back to the SIE. It also owns per-endpoint DATA0/DATA1 sequencing and the HALT (STALL) state driven by the control endpoint.

---
 rtl/bulk_sched_pkg.sv | 16 +
 rtl/bulk_toggle_bank.sv | 36 +++
 rtl/bulk_endp_sched.sv | 148 ++++++++++++++
 tb/tb_bulk_endp_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bulk_sched_pkg.sv
// bulk_sched_pkg: shared scheduler state encoding and halt-bit index helpers.
// Contents: state_t (ST_IDLE/ST_IN/ST_OUT/ST_STALL), HALT_OUT/HALT_IN, halt_idx().
package bulk_sched_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IN    = 2'd1,
        ST_OUT   = 2'd2,
        ST_STALL = 2'd3
    } state_t;
    localparam int HALT_OUT = 0;
    localparam int HALT_IN  = 1;
    // Flat halt/toggle index of (slot, direction): bit 2k = OUT, 2k+1 = IN.
    function automatic int halt_idx(input int slot, input logic is_in);
        return 2 * slot + (is_in ? HALT_IN : HALT_OUT);
    endfunction
endpackage

// File: rtl/bulk_toggle_bank.sv
// bulk_toggle_bank: per-slot DATA0/DATA1 toggles and halt bits.
// Ports: clk_i/rstn_i clock and async active-low reset; cfg_reset_i clears all;
//        halt_set_i/halt_clr_i per-bit halt control (clr wins, clr also zeroes
//        that direction's toggle); in_flip_i/out_flip_i per-slot toggle flips;
//        halt_o, in_tog_o, out_tog_o current register values.
module bulk_toggle_bank
    import bulk_sched_pkg::*;
#(
    parameter int N_ENDP = 2
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                cfg_reset_i,
    input  logic [2*N_ENDP-1:0] halt_set_i,
    input  logic [2*N_ENDP-1:0] halt_clr_i,
    input  logic [N_ENDP-1:0]   in_flip_i,
    input  logic [N_ENDP-1:0]   out_flip_i,
    output logic [2*N_ENDP-1:0] halt_o,
    output logic [N_ENDP-1:0]   in_tog_o,
    output logic [N_ENDP-1:0]   out_tog_o
);
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i || cfg_reset_i) begin
            halt_o    <= '0;
            in_tog_o  <= '0;
            out_tog_o <= '0;
        end else begin
            halt_o <= (halt_o | halt_set_i) & ~halt_clr_i;
            // A clear overrides a same-cycle flip, leaving DATA0.
            for (int k = 0; k < N_ENDP; k++) begin
                out_tog_o[k] <= ~halt_clr_i[halt_idx(k, 1'b0)] & (out_tog_o[k] ^ out_flip_i[k]);
                in_tog_o[k]  <= ~halt_clr_i[halt_idx(k, 1'b1)] & (in_tog_o[k] ^ in_flip_i[k]);
            end
        end
    end
endmodule

// File: rtl/bulk_endp_sched.sv
// bulk_endp_sched: routes SIE transactions to N_ENDP bulk endpoints with toggle/halt handling.
// Ports: clk_i/rstn_i clock and async active-low reset; token_* decoded token;
//        in_*/out_* SIE handshake and muxed results; stall_o STALL request;
//        ep_* per-slot gated handshake to the endpoints; cfg_* halt control
//        and bus reset; halt_o halt bits for GET_STATUS.
module bulk_endp_sched
    import bulk_sched_pkg::*;
#(
    parameter int N_ENDP     = 2,
    parameter int FIRST_ENDP = 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                token_valid_i,
    input  logic                token_in_i,
    input  logic [3:0]          endp_i,
    input  logic                in_req_i,
    input  logic                in_ready_i,
    input  logic                out_valid_i,
    input  logic                out_err_i,
    input  logic                out_ready_i,
    input  logic                out_toggle_i,
    input  logic [7:0]          out_data_i,
    output logic [7:0]          in_data_o,
    output logic                in_valid_o,
    output logic                out_nak_o,
    output logic                stall_o,
    output logic                in_toggle_o,
    input  logic [8*N_ENDP-1:0] ep_in_data_i,
    input  logic [N_ENDP-1:0]   ep_in_valid_i,
    input  logic [N_ENDP-1:0]   ep_out_nak_i,
    output logic [N_ENDP-1:0]   ep_in_req_o,
    output logic [N_ENDP-1:0]   ep_in_ready_o,
    output logic [N_ENDP-1:0]   ep_out_valid_o,
    output logic [N_ENDP-1:0]   ep_out_err_o,
    output logic [N_ENDP-1:0]   ep_out_ready_o,
    output logic [7:0]          ep_out_data_o,
    input  logic [2*N_ENDP-1:0] cfg_halt_set_i,
    input  logic [2*N_ENDP-1:0] cfg_halt_clr_i,
    input  logic                cfg_reset_i,
    output logic [2*N_ENDP-1:0] halt_o
);
    localparam int SW = N_ENDP > 1 ? $clog2(N_ENDP) : 1;

    state_t              state;
    logic [SW-1:0]       sel;
    logic [4:0]          diff;
    logic                in_range;
    logic [SW-1:0]       tok_sel;
    logic [2*N_ENDP-1:0] halt_sh;
    logic                tok_halt;
    logic [N_ENDP-1:0]   sel_oh;
    logic [N_ENDP-1:0]   gate;
    logic [N_ENDP-1:0]   in_tog;
    logic [N_ENDP-1:0]   out_tog;
    logic [N_ENDP-1:0]   in_flip;
    logic [N_ENDP-1:0]   out_flip;
    logic                in_end;
    logic                out_end;
    logic                nak;
    logic                retry;

    // Negative differences set bit 4 and are rejected.
    assign diff     = {1'b0, endp_i} - 5'(FIRST_ENDP);
    assign in_range = ~diff[4] && (diff < 5'(N_ENDP));
    assign tok_sel  = diff[SW-1:0];
    assign halt_sh  = halt_o >> {tok_sel, token_in_i};
    assign tok_halt = halt_sh[0];

    assign sel_oh  = N_ENDP'(1) << sel;
    // A same-cycle token aborts the old transaction, so nothing reaches the old slot.
    assign gate    = token_valid_i ? '0 : sel_oh;
    assign in_end  = out_ready_i & (out_err_i | ~out_valid_i);
    assign out_end = out_ready_i & ~out_valid_i;
    assign nak     = |(ep_out_nak_i & sel_oh);
    assign retry   = out_toggle_i ^ |(out_tog & sel_oh);

    assign ep_out_data_o = out_data_i;

    always_comb begin
        ep_in_req_o    = '0;
        ep_in_ready_o  = '0;
        ep_out_valid_o = '0;
        ep_out_err_o   = '0;
        ep_out_ready_o = '0;
        in_flip        = '0;
        out_flip       = '0;
        in_data_o      = '0;
        in_valid_o     = 1'b0;
        out_nak_o      = 1'b0;
        stall_o        = 1'b0;
        in_toggle_o    = 1'b0;
        case (state)
            ST_IN: begin
                ep_in_req_o    = {N_ENDP{in_req_i}} & gate;
                ep_in_ready_o  = {N_ENDP{in_ready_i}} & gate;
                ep_out_ready_o = {N_ENDP{in_end}} & gate;
                ep_out_err_o   = {N_ENDP{out_ready_i & out_err_i}} & gate;
                in_flip        = {N_ENDP{in_end & ~out_err_i}} & gate;
                in_data_o      = 8'(ep_in_data_i >> {sel, 3'b000});
                in_valid_o     = |(ep_in_valid_i & sel_oh);
                in_toggle_o    = |(in_tog & sel_oh);
            end
            ST_OUT: begin
                ep_out_valid_o = {N_ENDP{out_valid_i}} & gate;
                ep_out_ready_o = {N_ENDP{out_ready_i}} & gate;
                // A repeated toggle is a retry: flag it as an error so the endpoint drops it.
                ep_out_err_o   = {N_ENDP{out_err_i | (out_end & ~nak & retry)}} & gate;
                out_flip       = {N_ENDP{out_end & ~out_err_i & ~nak & ~retry}} & gate;
                out_nak_o      = nak;
            end
            ST_STALL: stall_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
            sel   <= '0;
        end else if (cfg_reset_i) begin
            state <= ST_IDLE;
        end else if (token_valid_i) begin
            if (in_range) begin
                sel   <= tok_sel;
                state <= tok_halt ? ST_STALL : (token_in_i ? ST_IN : ST_OUT);
            end else begin
                state <= ST_IDLE;
            end
        end else if ((state == ST_IN && in_end) || (state == ST_OUT && out_end) ||
                     (state == ST_STALL && out_ready_i)) begin
            state <= ST_IDLE;
        end
    end

    bulk_toggle_bank #(.N_ENDP(N_ENDP)) u_bank (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .cfg_reset_i (cfg_reset_i),
        .halt_set_i  (cfg_halt_set_i),
        .halt_clr_i  (cfg_halt_clr_i),
        .in_flip_i   (in_flip),
        .out_flip_i  (out_flip),
        .halt_o      (halt_o),
        .in_tog_o    (in_tog),
        .out_tog_o   (out_tog)
    );
endmodule

// File: tb/tb_bulk_endp_sched.sv
// tb_bulk_endp_sched: directed plus randomized checks of bulk_endp_sched against a transaction-level model.
module tb_bulk_endp_sched;
    localparam int N = 2;
    localparam int FIRST = 1;

    logic         clk = 1'b0;
    logic         rstn_i;
    logic         token_valid_i, token_in_i;
    logic [3:0]   endp_i;
    logic         in_req_i, in_ready_i, out_valid_i, out_err_i, out_ready_i, out_toggle_i;
    logic [7:0]   out_data_i;
    logic [7:0]   in_data_o;
    logic         in_valid_o, out_nak_o, stall_o, in_toggle_o;
    logic [8*N-1:0] ep_in_data_i;
    logic [N-1:0] ep_in_valid_i, ep_out_nak_i;
    logic [N-1:0] ep_in_req_o, ep_in_ready_o, ep_out_valid_o, ep_out_err_o, ep_out_ready_o;
    logic [7:0]   ep_out_data_o;
    logic [2*N-1:0] cfg_halt_set_i, cfg_halt_clr_i, halt_o;
    logic         cfg_reset_i;

    always #5 clk = ~clk;

    bulk_endp_sched #(.N_ENDP(N), .FIRST_ENDP(FIRST)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .token_valid_i(token_valid_i), .token_in_i(token_in_i), .endp_i(endp_i),
        .in_req_i(in_req_i), .in_ready_i(in_ready_i), .out_valid_i(out_valid_i),
        .out_err_i(out_err_i), .out_ready_i(out_ready_i), .out_toggle_i(out_toggle_i),
        .out_data_i(out_data_i),
        .in_data_o(in_data_o), .in_valid_o(in_valid_o), .out_nak_o(out_nak_o),
        .stall_o(stall_o), .in_toggle_o(in_toggle_o),
        .ep_in_data_i(ep_in_data_i), .ep_in_valid_i(ep_in_valid_i), .ep_out_nak_i(ep_out_nak_i),
        .ep_in_req_o(ep_in_req_o), .ep_in_ready_o(ep_in_ready_o), .ep_out_valid_o(ep_out_valid_o),
        .ep_out_err_o(ep_out_err_o), .ep_out_ready_o(ep_out_ready_o), .ep_out_data_o(ep_out_data_o),
        .cfg_halt_set_i(cfg_halt_set_i), .cfg_halt_clr_i(cfg_halt_clr_i),
        .cfg_reset_i(cfg_reset_i), .halt_o(halt_o)
    );

    // Transaction-level model: what the SIE is talking to, and the endpoint bookkeeping.
    typedef enum int {K_IDLE, K_IN, K_OUT, K_STALL} kind_t;
    kind_t    kind;
    int       slot;
    bit       itog [N];
    bit       otog [N];
    bit [2*N-1:0] mhalt;

    int passed = 0;
    int total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [N-1:0] onehot(input int s);
        logic [N-1:0] v;
        v = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    task automatic idle_inputs();
        token_valid_i = 0; token_in_i = 0; endp_i = 0;
        in_req_i = 0; in_ready_i = 0; out_valid_i = 0; out_err_i = 0;
        out_ready_i = 0; out_toggle_i = 0;
        cfg_halt_set_i = '0; cfg_halt_clr_i = '0; cfg_reset_i = 0;
        ep_out_nak_i = '0;
    endtask

    task automatic token(input int ep, input bit is_in);
        @(negedge clk);
        token_valid_i = 1; token_in_i = is_in; endp_i = 4'(ep);
        @(posedge clk); #1;
        token_valid_i = 0;
        if (ep >= FIRST && ep < FIRST + N) begin
            slot = ep - FIRST;
            kind = mhalt[2*slot + (is_in ? 1 : 0)] ? K_STALL : (is_in ? K_IN : K_OUT);
        end else kind = K_IDLE;
    endtask

    task automatic cfg(input logic [2*N-1:0] set, input logic [2*N-1:0] clr, input bit rst);
        @(negedge clk);
        cfg_halt_set_i = set; cfg_halt_clr_i = clr; cfg_reset_i = rst;
        @(posedge clk); #1;
        cfg_halt_set_i = '0; cfg_halt_clr_i = '0; cfg_reset_i = 0;
        if (rst) begin
            mhalt = '0; kind = K_IDLE;
            for (int k = 0; k < N; k++) begin itog[k] = 0; otog[k] = 0; end
        end else begin
            mhalt = (mhalt | set) & ~clr;
            for (int k = 0; k < N; k++) begin
                if (clr[2*k]) otog[k] = 0;
                if (clr[2*k+1]) itog[k] = 0;
            end
        end
    endtask

    // Mid-transaction snapshot: routing, muxes and halt status.
    task automatic peek(input string tag);
        logic [N-1:0] oh;
        logic [7:0] d [N];
        @(negedge clk);
        ep_in_data_i = 16'($urandom);
        ep_in_valid_i = N'($urandom);
        for (int k = 0; k < N; k++) d[k] = ep_in_data_i[8*k +: 8];
        in_req_i = 1; in_ready_i = 1; out_valid_i = 1; out_data_i = 8'($urandom);
        #1;
        oh = onehot(slot);
        chk({tag, ":ep_in_req"}, 32'(ep_in_req_o), 32'(kind == K_IN ? oh : '0));
        chk({tag, ":ep_in_ready"}, 32'(ep_in_ready_o), 32'(kind == K_IN ? oh : '0));
        chk({tag, ":ep_out_valid"}, 32'(ep_out_valid_o), 32'(kind == K_OUT ? oh : '0));
        chk({tag, ":in_data"}, 32'(in_data_o), 32'(kind == K_IN ? d[slot] : 8'd0));
        chk({tag, ":in_valid"}, 32'(in_valid_o), 32'(kind == K_IN ? ep_in_valid_i[slot] : 1'b0));
        chk({tag, ":in_toggle"}, 32'(in_toggle_o), 32'(kind == K_IN ? itog[slot] : 1'b0));
        chk({tag, ":stall"}, 32'(stall_o), 32'(kind == K_STALL));
        chk({tag, ":halt"}, 32'(halt_o), 32'(mhalt));
        chk({tag, ":out_data"}, 32'(ep_out_data_o), 32'(out_data_i));
        in_req_i = 0; in_ready_i = 0; out_valid_i = 0;
    endtask

    // End-of-packet pulse from the SIE (ACK for IN, end of DATA for OUT).
    task automatic end_pulse(input string tag, input bit tog, input logic [N-1:0] nk, input bit err);
        logic [N-1:0] oh, er, ee;
        bit nak_s;
        @(negedge clk);
        ep_out_nak_i = nk; out_ready_i = 1; out_valid_i = 0; out_err_i = err; out_toggle_i = tog;
        #1;
        oh = onehot(slot);
        nak_s = nk[slot];
        er = '0; ee = '0;
        if (kind == K_IN) begin
            er = oh;
            ee = err ? oh : '0;
        end else if (kind == K_OUT) begin
            er = oh;
            ee = (err || (!nak_s && tog != otog[slot])) ? oh : '0;
        end
        chk({tag, ":ep_out_ready"}, 32'(ep_out_ready_o), 32'(er));
        chk({tag, ":ep_out_err"}, 32'(ep_out_err_o), 32'(ee));
        chk({tag, ":out_nak"}, 32'(out_nak_o), 32'(kind == K_OUT && nak_s));
        chk({tag, ":ep_in_req0"}, 32'(ep_in_req_o), 32'(0));
        @(posedge clk); #1;
        out_ready_i = 0; out_err_i = 0; ep_out_nak_i = '0;
        if (kind == K_IN && !err) itog[slot] = ~itog[slot];
        if (kind == K_OUT && !err && !nak_s && tog == otog[slot]) otog[slot] = ~otog[slot];
        kind = K_IDLE;
    endtask

    initial begin
        idle_inputs();
        ep_in_data_i = '0; ep_in_valid_i = '0; out_data_i = '0;
        kind = K_IDLE; slot = 0; mhalt = '0;
        for (int k = 0; k < N; k++) begin itog[k] = 0; otog[k] = 0; end
        rstn_i = 0;
        #12;
        chk("rst:in_data", 32'(in_data_o), 0);
        chk("rst:stall", 32'(stall_o), 0);
        chk("rst:halt", 32'(halt_o), 0);
        chk("rst:ep_out_ready", 32'(ep_out_ready_o), 0);
        chk("rst:in_toggle", 32'(in_toggle_o), 0);
        rstn_i = 1;
        @(posedge clk); #1;

        // Two ACKed INs on slot 0, then a clear of its IN halt/toggle bit.
        token(1, 1); peek("in1");
        chk("in1:tog0", 32'(in_toggle_o), 0);
        end_pulse("in1", 0, '0, 0);
        token(1, 1); peek("in2");
        chk("in2:tog1", 32'(in_toggle_o), 1);
        end_pulse("in2", 0, '0, 0);
        cfg('0, 4'b0010, 0);
        token(1, 1); peek("in3");
        end_pulse("in3", 0, '0, 0);

        // OUT to endpoint 2 with DATA0, then the same DATA0 again (retry).
        token(2, 0); peek("out1");
        end_pulse("out1", 0, '0, 0);
        chk("out1:flip", 32'(otog[1]), 1);
        token(2, 0);
        end_pulse("out2", 0, '0, 0);
        token(2, 0);
        end_pulse("out3", 1, '0, 0);

        // Halted IN answers STALL; bus reset clears halts.
        cfg(4'b0010, '0, 0);
        token(1, 1); peek("stall");
        cfg('0, '0, 1); peek("cfgrst");

        // NAKed OUT, out-of-range tokens, and an aborted IN.
        token(1, 0); end_pulse("nak", 0, 2'b01, 0);
        token(9, 1); peek("ep9");
        token(0, 0); peek("ep0");
        token(1, 1); token(2, 0); peek("abort");
        end_pulse("abort", 0, '0, 0);
        token(1, 1); peek("abort_in");

        // Randomized operation mix.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: token(($urandom_range(0, 7) == 0) ? $urandom_range(3, 15) : $urandom_range(1, 2),
                               1'($urandom));
                3, 4, 5: end_pulse("rnd", 1'($urandom), N'($urandom_range(0, 3) == 0 ? $urandom : 0),
                                   $urandom_range(0, 5) == 0);
                6: cfg(($urandom_range(0, 2) == 0) ? 4'($urandom) : '0,
                       ($urandom_range(0, 2) == 0) ? 4'($urandom) : '0,
                       $urandom_range(0, 15) == 0);
                default: peek("rnd");
            endcase
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
